fifo_write_arbiter: RTL and testbench

- Shares the single write port of the project FIFO between NUM_REQ producers, for example a UART RX, a button debouncer and a timer tick source.
- Arbitration is round-robin at packet granularity. A granted producer keeps the port until it presents its last beat, or until MAX_BURST beats have been written.
- The block drives the FIFO write_en and data_in directly and never writes while the FIFO reports full.

---
 rtl/fifo_write_arbiter.sv | 128 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-granular arbiter sharing one FIFO write port among NUM_REQ producers.
// A grant lasts until the owner's last beat or MAX_BURST beats, whichever comes first.
`timescale 1ns/1ps
module fifo_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            grant,
    input  logic                          fifo_full,
    output logic                          fifo_write_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_reg, state_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic               busy_reg, busy_next;
    logic [7:0]         beat_cnt_reg, beat_cnt_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    logic [IDX_W-1:0]   last_owner_reg, last_owner_next;

    logic [DATA_WIDTH-1:0] req_slice [NUM_REQ];
    logic [IDX_W:0]        cand_sum  [NUM_REQ];
    logic [IDX_W-1:0]      cand_idx  [NUM_REQ];
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_found;
    logic                  in_grant;
    logic                  xfer;
    logic                  burst_end;

    // cand_idx[k] is the k-th requester in priority order after last_owner; wrap handled
    // explicitly so non-power-of-2 NUM_REQ rotates correctly.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_slice[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign cand_sum[gi]  = {1'b0, last_owner_reg} + (IDX_W+1)'(gi + 1);
            assign cand_idx[gi]  = (cand_sum[gi] >= (IDX_W+1)'(NUM_REQ))
                                 ? IDX_W'(cand_sum[gi] - (IDX_W+1)'(NUM_REQ))
                                 : cand_sum[gi][IDX_W-1:0];
            assign req_ready[gi] = in_grant && (owner_reg == IDX_W'(gi)) && !fifo_full;
        end
    endgenerate

    // Scan from lowest priority to highest so the earliest candidate wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[cand_idx[k]]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx[k];
            end
        end
    end

    assign in_grant      = (state_reg == GRANT);
    assign xfer          = in_grant && req_valid[owner_reg] && !fifo_full;
    assign burst_end     = (beat_cnt_reg == 8'(MAX_BURST - 1));
    assign fifo_write_en = xfer;
    assign fifo_data_in  = in_grant ? req_slice[owner_reg] : '0;
    assign grant         = grant_reg;
    assign busy          = busy_reg;

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        busy_next       = busy_reg;
        beat_cnt_next   = beat_cnt_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    state_next    = GRANT;
                    grant_next    = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    busy_next     = 1'b1;
                    owner_next    = pick_idx;
                    beat_cnt_next = 8'd0;
                end
            end
            GRANT: begin
                if (xfer) begin
                    if (req_last[owner_reg] || burst_end) begin
                        state_next      = IDLE;
                        grant_next      = '0;
                        busy_next       = 1'b0;
                        last_owner_next = owner_reg;
                        beat_cnt_next   = 8'd0;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 8'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            busy_reg       <= 1'b0;
            beat_cnt_reg   <= 8'd0;
            owner_reg      <= '0;
            last_owner_reg <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            busy_reg       <= busy_next;
            beat_cnt_reg   <= beat_cnt_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: a packet-level model checked every cycle,
// plus hand-written FIFO-content and grant-order expectations per scenario.
`timescale 1ns/1ps
module tb_fifo_write_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_last  = '0;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic        fifo_full = 1'b0;
    logic        fifo_write_en;
    logic [7:0]  fifo_data_in;
    logic        busy;

    logic [2:0]  r3_valid = '0;
    logic [23:0] r3_data  = {8'h32, 8'h31, 8'h30};
    logic [2:0]  r3_last  = '0;
    logic [2:0]  r3_ready;
    logic [2:0]  r3_grant;
    logic        r3_full = 1'b0;
    logic        r3_wen;
    logic [7:0]  r3_dout;
    logic        r3_busy;

    fifo_write_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(8)) u_dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant), .fifo_full(fifo_full),
        .fifo_write_en(fifo_write_en), .fifo_data_in(fifo_data_in), .busy(busy));

    fifo_write_arbiter #(.DATA_WIDTH(8), .NUM_REQ(3), .MAX_BURST(8)) u_dut3 (
        .clock(clock), .reset(reset), .req_valid(r3_valid), .req_data(r3_data),
        .req_last(r3_last), .req_ready(r3_ready), .grant(r3_grant), .fifo_full(r3_full),
        .fifo_write_en(r3_wen), .fifo_data_in(r3_dout), .busy(r3_busy));

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Producer queues: {last, data} per beat.
    logic [8:0] pq [4][$];
    logic [7:0] wlog [$];
    logic [3:0] glog [$];
    logic [7:0] wlog3 [$];
    logic [2:0] glog3 [$];
    logic [7:0] exp_q [$];
    logic [3:0] exp_g [$];
    logic [3:0] prev_grant = '0;
    logic [2:0] prev_grant3 = '0;

    // Packet-level model: owner (-1 when idle), last owner, beats written in this grant.
    int m_owner = -1;
    int m_last  = 3;
    int m_beats = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_owner = -1;
        m_last  = 3;
        m_beats = 0;
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        pq[r].push_back({l, d});
    endtask

    task automatic drive_inputs();
        logic [8:0] h;
        for (int i = 0; i < 4; i++) begin
            if (pq[i].size() > 0) begin
                h = pq[i][0];
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = h[7:0];
                req_last[i]        = h[8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    function automatic bit drained();
        return (m_owner < 0) && pq[0].size() == 0 && pq[1].size() == 0
            && pq[2].size() == 0 && pq[3].size() == 0;
    endfunction

    task automatic wait_drain(input int budget);
        int n = 0;
        while (!drained() && n < budget) begin
            @(posedge clock);
            n++;
        end
        chk("drain_timeout", 32'(drained()), 32'd1);
    endtask

    task automatic chk_wlog(input string name);
        chk({name, "_len"}, wlog.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
            chk({name, "_data"}, 32'(wlog[i]), 32'(exp_q[i]));
    endtask

    task automatic chk_glog(input string name);
        chk({name, "_glen"}, glog.size(), exp_g.size());
        for (int i = 0; i < exp_g.size() && i < glog.size(); i++)
            chk({name, "_grant"}, 32'(glog[i]), 32'(exp_g[i]));
    endtask

    always @(posedge clock) begin
        #1;
        drive_inputs();
    end

    // Per-cycle compare against the model, then advance the model past the next edge.
    always @(negedge clock) begin
        logic [3:0] e_grant, e_ready;
        logic       e_wen, e_busy;
        logic [7:0] e_data;
        int         c;
        if (reset) m_reset();
        e_busy  = (m_owner >= 0);
        e_grant = e_busy ? 4'(1 << m_owner) : 4'b0;
        e_ready = (e_busy && !fifo_full) ? e_grant : 4'b0;
        e_wen   = e_busy && req_valid[m_owner] && !fifo_full;
        e_data  = e_busy ? req_data[m_owner*8 +: 8] : 8'h00;
        chk("grant", 32'(grant), 32'(e_grant));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("write_en", 32'(fifo_write_en), 32'(e_wen));
        chk("data_in", 32'(fifo_data_in), 32'(e_data));
        chk("r3_busy", 32'(r3_busy), 32'(r3_grant != 3'b0));
        chk("r3_ready", 32'(r3_ready), 32'(r3_full ? 3'b0 : r3_grant));

        if (fifo_write_en) wlog.push_back(fifo_data_in);
        if (grant != 4'b0 && prev_grant == 4'b0) glog.push_back(grant);
        prev_grant = grant;
        if (r3_wen) wlog3.push_back(r3_dout);
        if (r3_grant != 3'b0 && prev_grant3 == 3'b0) glog3.push_back(r3_grant);
        prev_grant3 = r3_grant;

        if (!reset) begin
            if (m_owner < 0) begin
                for (int k = 1; k <= 4; k++) begin
                    c = (m_last + k) % 4;
                    if (m_owner < 0 && req_valid[c]) begin
                        m_owner = c;
                        m_beats = 0;
                    end
                end
            end else if (e_wen) begin
                m_beats++;
                if (req_last[m_owner] || m_beats == 8) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_beats = 0;
                end
                void'(pq[e_wen ? (m_owner < 0 ? m_last : m_owner) : 0].pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_wen", 32'(fifo_write_en), 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd0);

        // All four valid, single-beat packets: strict rotation 0,1,2,3 twice.
        @(posedge clock); #2;
        for (int i = 0; i < 4; i++) push(i, 8'(8'h10 + i), 1'b1);
        drive_inputs();
        wait_drain(40);
        #2;
        for (int i = 0; i < 4; i++) push(i, 8'(8'h20 + i), 1'b1);
        drive_inputs();
        wait_drain(40);
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23};
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        chk_wlog("rr_single");
        chk_glog("rr_single");
        $display("transaction rr_single: writes=%0d grants=%0d", wlog.size(), glog.size());

        // Requester 2's 3-beat packet waits for requester 0's packet, no interleave.
        wlog.delete(); glog.delete();
        #2;
        push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1);
        push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b0); push(2, 8'hA3, 1'b1);
        drive_inputs();
        wait_drain(40);
        exp_q = '{8'h01, 8'h02, 8'hA1, 8'hA2, 8'hA3};
        exp_g = '{4'b0001, 4'b0100};
        chk_wlog("no_interleave");
        chk_glog("no_interleave");
        $display("transaction no_interleave: writes=%0d", wlog.size());

        // 20-beat stream from requester 1 is cut at 8 beats; requester 3 slots in.
        wlog.delete(); glog.delete();
        #2;
        for (int k = 0; k < 20; k++) push(1, 8'(8'h40 + k), (k == 19));
        push(3, 8'hC0, 1'b0); push(3, 8'hC1, 1'b1);
        push(3, 8'hC2, 1'b0); push(3, 8'hC3, 1'b1);
        drive_inputs();
        wait_drain(120);
        exp_q = {};
        exp_q.push_back(8'hC0); exp_q.push_back(8'hC1);
        for (int k = 0; k < 8; k++) exp_q.push_back(8'(8'h40 + k));
        exp_q.push_back(8'hC2); exp_q.push_back(8'hC3);
        for (int k = 8; k < 20; k++) exp_q.push_back(8'(8'h40 + k));
        exp_g = '{4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b0010};
        chk_wlog("max_burst");
        chk_glog("max_burst");
        $display("transaction max_burst: writes=%0d grants=%0d", wlog.size(), glog.size());

        // FIFO full for 5 cycles after beat 2 of a 4-beat packet.
        wlog.delete(); glog.delete();
        #2;
        for (int k = 0; k < 4; k++) push(0, 8'(8'h60 + k), (k == 3));
        drive_inputs();
        n = 0;
        while (wlog.size() < 2 && n < 40) begin @(posedge clock); n++; end
        chk("stall_start_timeout", 32'(wlog.size() >= 2), 32'd1);
        #2 fifo_full = 1'b1;
        #1;
        chk("stall_wen", 32'(fifo_write_en), 32'd0);
        chk("stall_ready", 32'(req_ready), 32'd0);
        chk("stall_grant", 32'(grant), 32'b0001);
        repeat (5) @(posedge clock);
        #2 fifo_full = 1'b0;
        wait_drain(40);
        exp_q = '{8'h60, 8'h61, 8'h62, 8'h63};
        chk_wlog("full_stall");
        $display("transaction full_stall: writes=%0d", wlog.size());

        // Reset pulsed between edges during beat 2; then requester 0 wins first.
        wlog.delete(); glog.delete();
        #2;
        for (int k = 0; k < 4; k++) push(2, 8'(8'h70 + k), (k == 3));
        drive_inputs();
        n = 0;
        while (wlog.size() < 1 && n < 40) begin @(posedge clock); n++; end
        chk("rst_start_timeout", 32'(wlog.size() >= 1), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_wen", 32'(fifo_write_en), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        #1 reset = 1'b0;
        pq[2].delete();
        m_reset();
        push(0, 8'h80, 1'b1);
        push(2, 8'h82, 1'b1);
        drive_inputs();
        wait_drain(40);
        exp_q = '{8'h70, 8'h80, 8'h82};
        exp_g = '{4'b0100, 4'b0001, 4'b0100};
        chk_wlog("mid_reset");
        chk_glog("mid_reset");
        $display("transaction mid_reset: writes=%0d", wlog.size());

        // NUM_REQ=3: rotation must wrap from requester 2 back to 0.
        @(posedge clock); #2;
        r3_valid = 3'b111;
        r3_last  = 3'b111;
        repeat (12) @(posedge clock);
        #2 r3_valid = 3'b000;
        chk("wrap3_len", 32'(glog3.size() >= 4), 32'd1);
        if (glog3.size() >= 4) begin
            chk("wrap3_g0", 32'(glog3[0]), 32'b001);
            chk("wrap3_g1", 32'(glog3[1]), 32'b010);
            chk("wrap3_g2", 32'(glog3[2]), 32'b100);
            chk("wrap3_g3", 32'(glog3[3]), 32'b001);
        end
        chk("wrap3_wlen", 32'(wlog3.size() >= 4), 32'd1);
        if (wlog3.size() >= 4) begin
            chk("wrap3_d0", 32'(wlog3[0]), 32'h30);
            chk("wrap3_d3", 32'(wlog3[3]), 32'h30);
        end
        $display("transaction wrap3: grants=%0d writes=%0d", glog3.size(), wlog3.size());

        repeat (2) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
